// File: rtl/hall_emulator.sv
// Six-step hall sensor emulator with a live-sampled dwell period and electrical revolution counter.
// Define HALL_GLITCH_EN to compile in post-step bounce injection for exercising debounce filters.
module hall_emulator #(
   parameter int CNT_W = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_dir,
   input  logic [CNT_W-1:0] i_period,
   input  logic [3:0]       i_glitch_len,
   output logic [2:0]       o_hall,
   output logic             o_step_strobe,
   output logic [15:0]      o_rev_cnt
);

   localparam logic [2:0] HALL_RESET = 3'b101;

   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [2:0]       r_hall;
   logic             r_strobe;
   logic [15:0]      r_rev;

   logic [CNT_W-1:0] w_dwell_m1;
   logic             w_at_boundary;
   logic [2:0]       w_next_idx;
   logic             w_wrap;

   function automatic logic [2:0] hall_code(input logic [2:0] idx);
      logic [2:0] code;
      case (idx)
         3'd0:    code = 3'b101;
         3'd1:    code = 3'b100;
         3'd2:    code = 3'b110;
         3'd3:    code = 3'b010;
         3'd4:    code = 3'b011;
         3'd5:    code = 3'b001;
         default: code = HALL_RESET;
      endcase
      return code;
   endfunction

   // Dwell is clamped to two cycles, so the terminal count is never below one.
   assign w_dwell_m1    = (i_period < CNT_W'(2)) ? CNT_W'(1) : i_period - CNT_W'(1);
   assign w_at_boundary = (r_cnt >= w_dwell_m1);

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_next_idx = r_idx;
      w_wrap     = 1'b0;
      if (i_dir) begin
         w_wrap     = (r_idx == 3'd0);
         w_next_idx = w_wrap ? 3'd5 : r_idx - 3'd1;
      end else begin
         w_wrap     = (r_idx == 3'd5);
         w_next_idx = w_wrap ? 3'd0 : r_idx + 3'd1;
      end
   end

`ifdef HALL_GLITCH_EN
   logic [3:0] r_glitch_cnt;
   logic [2:0] r_prev_hall;
`else
   logic [3:0] w_unused_glitch_len;
   assign w_unused_glitch_len = i_glitch_len;
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_cnt    <= '0;
         r_idx    <= 3'd0;
         r_hall   <= HALL_RESET;
         r_strobe <= 1'b0;
         r_rev    <= 16'd0;
`ifdef HALL_GLITCH_EN
         r_glitch_cnt <= 4'd0;
         r_prev_hall  <= HALL_RESET;
`endif
      end else begin
         r_strobe <= 1'b0;
         if (i_enable) begin
            if (w_at_boundary) begin
               r_cnt    <= '0;
               r_idx    <= w_next_idx;
               r_strobe <= 1'b1;
               r_hall   <= hall_code(w_next_idx);
               if (w_wrap) r_rev <= r_rev + 16'd1;
`ifdef HALL_GLITCH_EN
               // A new step restarts the bounce, truncating any bounce still running.
               r_glitch_cnt <= i_glitch_len;
               r_prev_hall  <= hall_code(r_idx);
`endif
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
`ifdef HALL_GLITCH_EN
               if (r_glitch_cnt != 4'd0) begin
                  r_glitch_cnt <= r_glitch_cnt - 4'd1;
                  r_hall       <= r_prev_hall;
               end else begin
                  r_hall <= hall_code(r_idx);
               end
`endif
            end
         end
      end
   end

   assign o_hall        = r_hall;
   assign o_step_strobe = r_strobe;
   assign o_rev_cnt     = r_rev;

endmodule

// File: tb/tb_hall_emulator.sv
// Scoreboard bench for hall_emulator: directed scenarios push expected steps, a monitor checks each strobe.
module tb_hall_emulator;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             dir;
   logic [CNT_W-1:0] period;
   logic [3:0]       glen;
   logic [2:0]       hall;
   logic             strobe;
   logic [15:0]      rev;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [2:0]  hall;
      logic [15:0] rev;
      int          at;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hall_emulator #(.CNT_W(CNT_W)) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_enable     (en),
      .i_dir        (dir),
      .i_period     (period),
      .i_glitch_len (glen),
      .o_hall       (hall),
      .o_step_strobe(strobe),
      .o_rev_cnt    (rev)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [2:0] h, input logic [15:0] r, input int at);
      exp_t e;
      e.hall = h;
      e.rev  = r;
      e.at   = at;
      q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   // Monitor: every strobe must match the oldest expected step.
   always @(negedge clk) begin
      if (strobe === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("step_hall", 32'(hall), 32'(e.hall));
            check("step_rev", 32'(rev), 32'(e.rev));
            check("step_cycle", cyc, e.at);
         end
      end
   end

   initial begin
      int b;
      logic [2:0] bounce_hall;
      rst    = 1'b1;
      en     = 1'b1;
      dir    = 1'b0;
      period = 16'd4;
      glen   = 4'd0;
      tick(2);
      check("reset_hall", 32'(hall), 32'(3'b101));
      check("reset_strobe", 32'(strobe), 32'(1'b0));
      check("reset_rev", 32'(rev), 32'(16'd0));

      // Forward, period 4: one full electrical revolution.
      rst = 1'b0;
      b   = cyc;
      push(3'b100, 16'd0, b + 4);
      push(3'b110, 16'd0, b + 8);
      push(3'b010, 16'd0, b + 12);
      push(3'b011, 16'd0, b + 16);
      push(3'b001, 16'd0, b + 20);
      push(3'b101, 16'd1, b + 24);
      tick(24);
      check("fwd_rev_after_24", 32'(rev), 32'(16'd1));

      // Reverse, period 3: 0->5 counts a revolution; later a mid-dwell dir flip.
      apply_reset();
      dir    = 1'b1;
      period = 16'd3;
      b      = cyc;
      push(3'b001, 16'd1, b + 3);
      push(3'b011, 16'd1, b + 6);
      push(3'b010, 16'd1, b + 9);
      push(3'b110, 16'd1, b + 12);
      push(3'b100, 16'd1, b + 15);
      push(3'b101, 16'd1, b + 18);
      push(3'b001, 16'd2, b + 21);
      tick(16);
      dir = 1'b0;
      tick(1);
      dir = 1'b1;
      tick(4);

      // Periods 0 and 1 clamp to a 2-cycle dwell.
      apply_reset();
      dir    = 1'b0;
      period = 16'd0;
      b      = cyc;
      push(3'b100, 16'd0, b + 2);
      push(3'b110, 16'd0, b + 4);
      push(3'b010, 16'd0, b + 6);
      push(3'b011, 16'd0, b + 8);
      tick(4);
      period = 16'd1;
      tick(4);

      // Freeze at counter 5, resume, then drop period below the counter.
      apply_reset();
      period = 16'd10;
      b      = cyc;
      push(3'b100, 16'd0, b + 17);
      push(3'b110, 16'd0, b + 24);
      tick(5);
      en = 1'b0;
      tick(7);
      check("frozen_hall", 32'(hall), 32'(3'b101));
      check("frozen_strobe", 32'(strobe), 32'(1'b0));
      en = 1'b1;
      tick(11);
      period = 16'd2;
      tick(1);

      // Reset mid-dwell at index 3.
      apply_reset();
      period = 16'd4;
      b      = cyc;
      push(3'b100, 16'd0, b + 4);
      push(3'b110, 16'd0, b + 8);
      push(3'b010, 16'd0, b + 12);
      tick(14);
      check("pre_reset_hall", 32'(hall), 32'(3'b010));
      rst = 1'b1;
      tick(1);
      check("midreset_hall", 32'(hall), 32'(3'b101));
      check("midreset_rev", 32'(rev), 32'(16'd0));
      check("midreset_strobe", 32'(strobe), 32'(1'b0));
      rst = 1'b0;

      // Bounce: previous code shown for glitch_len cycles after a step.
      apply_reset();
      period = 16'd8;
      glen   = 4'd2;
`ifdef HALL_GLITCH_EN
      bounce_hall = 3'b101;
`else
      bounce_hall = 3'b100;
`endif
      b = cyc;
      push(3'b100, 16'd0, b + 8);
      tick(8);
      check("glitch_t0", 32'(hall), 32'(3'b100));
      tick(1);
      check("glitch_t1", 32'(hall), 32'(bounce_hall));
      check("glitch_t1_strobe", 32'(strobe), 32'(1'b0));
      tick(1);
      check("glitch_t2", 32'(hall), 32'(bounce_hall));
      tick(1);
      check("glitch_t3", 32'(hall), 32'(3'b100));

      glen = 4'd0;
      en   = 1'b0;
      tick(2);
      check("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
